// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 3x3 median datapath. It scans the image one 3-pixel column at a time,
// drives the read port and load enables, and tags each window with its output address.
module median_frame_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              en1,
    output logic              en2,
    output logic              out_valid,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int CW   = $clog2(WIDTH);
    localparam int RW   = $clog2(HEIGHT);
    localparam int TAGS = 4;

    localparam logic [CW-1:0]     C_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]     C_VLAST  = CW'(WIDTH - 3);
    localparam logic [RW-1:0]     R_LAST   = RW'(HEIGHT - 3);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StFin} state_e;

    state_e            state_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [1:0]        phase_q;
    logic [2:0]        flush_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] out_cnt_q;
    logic              pend_valid_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              tag_valid_q [TAGS];
    logic [ADDR_W-1:0] tag_addr_q  [TAGS];

    logic last_read;
    logic col_keep;

    always_comb begin
        last_read = (phase_q == 2'd2) && (row_q == R_LAST) && (col_q == C_LAST);
        col_keep  = (col_q <= C_VLAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            phase_q      <= '0;
            flush_q      <= '0;
            base_q       <= '0;
            out_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            for (int i = 0; i < TAGS; i++) begin
                tag_valid_q[i] <= 1'b0;
                tag_addr_q[i]  <= '0;
            end
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            en1       <= 1'b0;
            en2       <= 1'b0;
            out_valid <= 1'b0;
            wr_addr   <= '0;
        end else begin
            en1       <= 1'b0;
            en2       <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;

            // Tag pipe mirrors the datapath: the tag leaving stage 3 matches the median
            // that appears on o_med during the next cycle.
            if (en2) begin
                tag_valid_q[0] <= pend_valid_q;
                tag_addr_q[0]  <= pend_addr_q;
                for (int i = 1; i < TAGS; i++) begin
                    tag_valid_q[i] <= tag_valid_q[i-1];
                    tag_addr_q[i]  <= tag_addr_q[i-1];
                end
                out_valid <= tag_valid_q[TAGS-1];
                if (tag_valid_q[TAGS-1]) begin
                    wr_addr <= tag_addr_q[TAGS-1];
                end
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StRun;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        base_q    <= '0;
                        row_q     <= '0;
                        col_q     <= '0;
                        phase_q   <= '0;
                        out_cnt_q <= '0;
                    end
                end

                StRun: begin
                    // Enables follow the read phase by one cycle to absorb memory latency.
                    en1 <= (phase_q != 2'd2);
                    en2 <= (phase_q == 2'd2);
                    if (phase_q == 2'd2) begin
                        pend_valid_q <= col_keep;
                        pend_addr_q  <= out_cnt_q;
                        if (col_keep) begin
                            out_cnt_q <= out_cnt_q + 1'b1;
                        end
                    end

                    if (last_read) begin
                        state_q <= StFlush;
                        rd_en   <= 1'b0;
                        flush_q <= '0;
                    end else if (phase_q != 2'd2) begin
                        phase_q <= phase_q + 2'd1;
                        rd_addr <= rd_addr + ROW_STEP;
                    end else begin
                        // Row-major layout: the next column's top pixel is always base + 1,
                        // including the wrap onto the next output row.
                        phase_q <= '0;
                        base_q  <= base_q + 1'b1;
                        rd_addr <= base_q + 1'b1;
                        if (col_q == C_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                StFlush: begin
                    flush_q <= flush_q + 3'd1;
                    if (flush_q == 3'd2 || flush_q == 3'd5) begin
                        en2          <= 1'b1;
                        pend_valid_q <= 1'b0;
                    end
                    if (flush_q == 3'd7) begin
                        state_q <= StFin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end

                StFin: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Scoreboard bench for median_frame_ctrl: a timeline model of the frame plus an emulated
// median datapath fed from a behavioural frame memory.
module tb_median_frame_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 8;
    localparam int N  = (H - 2) * W;

    typedef struct {
        int cyc;
        bit rd_en;
        int rd_addr;
        bit en1;
        bit en2;
        bit busy;
        bit done;
    } ctl_t;

    typedef struct {
        int cyc;
        int wa;
        int val;
    } out_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, rd_en, en1, en2, out_valid;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    rd_data = 8'd0;

    int   img [W*H];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_done = -1;
    ctl_t exp_c[$];
    out_t exp_o[$];
    int   col_pix[$];
    int   tmp0 = 0;
    int   tmp1 = 0;

    median_frame_ctrl #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .en1       (en1),
        .en2       (en2),
        .out_valid (out_valid),
        .wr_addr   (wr_addr)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < W * H) rd_data <= 8'(img[rd_addr]);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int med9(input int v[9]);
        int a[9];
        int t;
        a = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        return a[4];
    endfunction

    function automatic int med_img(input int r, input int c);
        int a[9];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i*3+j] = img[(r+i)*W + c + j];
        return med9(a);
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    1:       img[r*W+c] = (r == 1 && c == 1) ? 255 : 7;
                    2:       img[r*W+c] = r * W + c;
                    default: img[r*W+c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // Expected frame timeline when start is accepted in cycle s.
    task automatic launch();
        int   s;
        int   k, j, m, n;
        ctl_t e;
        out_t o;
        s = cyc;
        col_pix.delete();
        last_done = s + 3 * N + 9;
        for (int t = s + 1; t <= last_done; t++) begin
            k = t - s - 1;
            j = t - s - 2;
            m = t - s - 4;
            e.cyc     = t;
            e.rd_en   = (k >= 0 && k < 3 * N);
            n         = k / 3;
            e.rd_addr = e.rd_en ? ((n / W + k % 3) * W + n % W) : 0;
            e.en1     = (j >= 0 && j < 3 * N && j % 3 != 2);
            e.en2     = (m >= 0 && m % 3 == 0 && m / 3 <= N + 1);
            e.busy    = (t < last_done);
            e.done    = (t == last_done);
            exp_c.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            if (i % W <= W - 3) begin
                o.cyc = s + 17 + 3 * i;
                o.wa  = (i / W) * (W - 2) + i % W;
                o.val = med_img(i / W, i % W);
                exp_o.push_back(o);
            end
        end
    endtask

    task automatic tick(input bit s);
        start = s;
        if (s && !rst && cyc > last_done) launch();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst(input int ncyc);
        rst = 1'b1;
        start = 1'b0;
        exp_c.delete();
        exp_o.delete();
        col_pix.delete();
        last_done = -1;
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit noisy);
        fill(mode);
        tick(1'b1);
        while (cyc <= last_done) tick(noisy ? ($urandom_range(0, 3) == 0) : 1'b0);
    endtask

    // Monitor: every cycle compares control outputs and pops output events as they appear.
    initial begin
        ctl_t e;
        out_t o;
        int   act;
        int   win[9];
        bit   exp_ov;
        forever begin
            @(negedge clk);
            e.cyc = cyc; e.rd_en = 0; e.rd_addr = 0; e.en1 = 0; e.en2 = 0;
            e.busy = 0; e.done = 0;
            if (exp_c.size() > 0 && exp_c[0].cyc <= cyc) e = exp_c.pop_front();
            check("ctl{rd_en,en1,en2,busy,done}", int'({rd_en, en1, en2, busy, done}),
                  int'({e.rd_en, e.en1, e.en2, e.busy, e.done}));
            if (e.rd_en) check("rd_addr", int'(rd_addr), e.rd_addr);

            if (en1) begin
                tmp0 = tmp1;
                tmp1 = int'(rd_data);
            end
            if (en2) begin
                col_pix.push_back(tmp0);
                col_pix.push_back(tmp1);
                col_pix.push_back(int'(rd_data));
            end

            while (exp_o.size() > 0 && exp_o[0].cyc < cyc) void'(exp_o.pop_front());
            exp_ov = (exp_o.size() > 0 && exp_o[0].cyc == cyc);
            check("out_valid", int'(out_valid), int'(exp_ov));
            if (out_valid && exp_ov) begin
                o = exp_o.pop_front();
                check("wr_addr", int'(wr_addr), o.wa);
                act = -1;
                if (col_pix.size() >= 15) begin
                    for (int i = 0; i < 9; i++) win[i] = col_pix[col_pix.size() - 15 + i];
                    act = med9(win);
                end
                check("median", act, o.val);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (20) tick(1'b0);

        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);

        // start held through most of the frame, then pulsed in the done cycle
        fill(0);
        tick(1'b1);
        repeat (30) tick(1'b1);
        while (cyc < last_done) tick(1'b0);
        tick(1'b1);
        repeat (5) tick(1'b0);

        // abort mid-frame, then a clean frame
        fill(0);
        tick(1'b1);
        repeat (19) tick(1'b0);
        apply_rst(2);
        repeat (2) tick(1'b0);
        run_frame(0, 1'b0);

        repeat (3) begin
            repeat ($urandom_range(0, 4)) tick(1'b0);
            run_frame(0, 1'b1);
        end

        repeat (10) tick(1'b0);
        check("ctl_left", exp_c.size(), 0);
        check("out_left", exp_o.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_frame_ctrl.md
Name: median_frame_ctrl

Overview:
- Frame-level sequencer for the 3x3 median datapath, which has an 8-bit pixel input and load enables en1/en2.
- Scans a row-major image in frame memory one 3-pixel column at a time and drives the memory read port, en1 and en2 with the correct cadence.
- Tracks each window through the datapath's 5-load pipeline and marks which o_med values are valid interior pixels.
- Produces write addresses for a (WIDTH-2)x(HEIGHT-2) output image, with start/busy/done handshake to the host.

Parameters:
- WIDTH, 640, image width in pixels (>=3)
- HEIGHT, 480, image height in pixels (>=3)
- ADDR_W, 19, read/write address width; must cover WIDTH*HEIGHT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle frame start request; sampled only in IDLE
- busy  out  1  high while state is RUN or FLUSH
- done  out  1  one-cycle pulse after the final valid output
- rd_en  out  1  frame memory read strobe; memory has fixed 1-cycle latency
- rd_addr  out  ADDR_W  read address = row*WIDTH + col
- en1  out  1  datapath column-shift enable
- en2  out  1  datapath column-load/pipeline-advance enable
- out_valid  out  1  the datapath's o_med is a valid interior pixel this cycle
- wr_addr  out  ADDR_W  output address = r*(WIDTH-2) + c

Behaviour:
- All outputs are registered. Reset drives all outputs to 0, state to IDLE, all counters to 0, and the tag pipe to invalid. Reset mid-frame aborts the frame: no done and no further out_valid.
- States:
  - IDLE: start=1 moves to RUN next cycle.
  - RUN: exits to FLUSH after the read of the last column's phase 2.
  - FLUSH: exits to FIN after the cycle carrying the final out_valid.
  - FIN: one cycle with done=1, then IDLE. start is ignored outside IDLE.
- Scan order in RUN:
  - Output row r runs 0..HEIGHT-3; column c runs 0..WIDTH-1. Column index n counts columns across the whole frame, N = (HEIGHT-2)*WIDTH.
  - Each column takes 3 cycles, phase p = 0,1,2, with rd_en=1 and rd_addr=(r+p)*WIDTH+c.
  - There are no bubbles between columns or rows. A row reads WIDTH columns, so cross-row windows occur and are masked.
- Enable timing, with dp = read phase delayed one cycle to match memory latency:
  - en1 = 1 when dp is 0 or 1.
  - en2 = 1 when dp is 2. This is the same cycle the column's third pixel is on the data input.
  - en2 for column n therefore occurs 3 cycles after that column's first read.
- FLUSH:
  - rd_en=0 and en1=0.
  - Issues exactly 2 more en2 pulses, at 3-cycle spacing after the last column's en2.
- Tag pipe: 4-entry shift register of {valid, wr_addr}, advanced only on en2.
  - The tag is written on column n's en2: valid = (c <= WIDTH-3), address = r*(WIDTH-2)+c.
  - Flush pulses shift in invalid tags.
  - A window loaded at en2 pulse n has its median on o_med in the cycle after pulse n+4.
  - out_valid = that tag's valid bit, registered so it is high exactly in the cycle after pulse n+4, for 1 cycle; wr_addr is held with it.
- Valid outputs are strictly increasing in wr_addr 0..(WIDTH-2)*(HEIGHT-2)-1, with exactly (WIDTH-2)*(HEIGHT-2) per frame.
- Counters: c wraps at WIDTH-1 to 0 and increments r. The end of RUN is r=HEIGHT-3, c=WIDTH-1, p=2.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> all outputs stay 0; assert rst mid-stream -> outputs 0 in the same cycle.
- WIDTH=5, HEIGHT=4, start sampled cycle 0:
  - rd_en high cycles 1..30; rd_addr sequence 0,5,10,1,6,11,... ending 9,14,19.
  - en2 at 4,7,...,31,34,37.
  - out_valid at cycles 17,20,23,32,35,38 with wr_addr 0..5.
  - done at 39; busy high 1..38.
- Same config, image with all pixels 7 except a single 255 at (1,1) -> first output (wr_addr 0) = 7; every out_valid value = 7.
- Same config, ramp image pixel = row*5+col -> each output equals its centre pixel: values 6,7,8,11,12,13.
- start held high through the frame, and start pulsed during FIN -> exactly one frame runs; a new frame begins only from IDLE, cycle timing identical to the earlier run.
- rst asserted at cycle 20 of a frame, then new start -> no done for the aborted frame; the new frame reproduces the WIDTH=5, HEIGHT=4 timing exactly.
